// File: rtl/byte_mem_responder.sv
// Byte-addressed memory responder: four byte banks, unaligned 1-cycle reads and a
// serialised one-byte-per-cycle write engine with a four-phase done handshake.
module byte_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned ADDR_BITS   = 14
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] address_i,
  input  logic [1:0]  write_i,
  input  logic [7:0]  d0_i,
  input  logic [7:0]  d1_i,
  input  logic [7:0]  d2_i,
  input  logic [7:0]  d3_i,
  output logic [7:0]  q0_o,
  output logic [7:0]  q1_o,
  output logic [7:0]  q2_o,
  output logic [7:0]  q3_o,
  output logic        done_o,
  output logic        error_o
);

  localparam logic [32:0] MemBytes = 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWrite, StAck} state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [3:0][7:0]      wdat_q, wdat_d;
  logic [1:0]           last_q, last_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic [3:0][7:0]      rd_q, rd_d;

  logic [7:0] mem_q [4][DEPTH_WORDS];

  logic                 fault;
  logic [1:0]           req_last;
  logic [1:0]           wr_lane;
  logic [ADDR_BITS-1:0] wr_addr;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] rd_addr [4];

  always_comb begin
    unique case (write_i)
      2'd1:    req_last = 2'd0;
      2'd2:    req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
    fault = ({1'b0, address_i} >= MemBytes) ||
            ((write_i == 2'd2) && address_i[0]) ||
            ((write_i == 2'd3) && (address_i[1:0] != 2'd0));
  end

  // Lane index counts up while cnt_q counts down from n-1.
  always_comb begin
    wr_lane = last_q - cnt_q;
    wr_addr = addr_q + ADDR_BITS'(wr_lane);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (write_i != 2'd0) begin
          addr_d  = address_i[ADDR_BITS-1:0];
          wdat_d  = {d3_i, d2_i, d1_i, d0_i};
          last_d  = req_last;
          cnt_d   = req_last;
          err_d   = fault;
          state_d = fault ? StAck : StWrite;
        end
      end
      StWrite: begin
        wr_en = 1'b1;
        if (cnt_q == 2'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StAck: begin
        if (write_i == 2'd0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    done_d = (state_d == StAck);
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_addr[k] = address_i[ADDR_BITS-1:0] + ADDR_BITS'(k);
    end
  end

  // Read data is frozen while the write engine owns the banks.
  always_comb begin
    rd_d = rd_q;
    if (state_q != StWrite) begin
      for (int k = 0; k < 4; k++) begin
        rd_d[k] = mem_q[rd_addr[k][1:0]][rd_addr[k][ADDR_BITS-1:2]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdat_q  <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
    end
  end

  // Storage is not reset; reset only suppresses the pending byte.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) begin
      mem_q[wr_addr[1:0]][wr_addr[ADDR_BITS-1:2]] <= wdat_q[wr_lane];
    end
  end

  assign q0_o    = rd_q[0];
  assign q1_o    = rd_q[1];
  assign q2_o    = rd_q[2];
  assign q3_o    = rd_q[3];
  assign done_o  = done_q;
  assign error_o = err_q;

endmodule
